// File: rtl/l1_miss_ctrl_if.sv
// l1_miss_ctrl_if: all miss-sequencer buses (lookup, replacement, tag/data arrays, write-back, memory, perf).
// master = the miss controller, slave = the surrounding cache/memory environment.
interface l1_miss_ctrl_if #(
    parameter int NUM_SETS    = 64,
    parameter int NUM_WAYS    = 4,
    parameter int INDEX_BITS  = $clog2(NUM_SETS),
    parameter int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int DATA_W      = 32,
    parameter int LINE_BEATS  = 4,
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = $clog2(LINE_BEATS * DATA_W / 8),
    parameter int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS
);
    localparam int BEAT_BITS = $clog2(LINE_BEATS);

    logic                  miss_valid;
    logic                  miss_ready;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  miss_done;

    logic [INDEX_BITS-1:0] repl_index;
    logic [WAY_BITS-1:0]   repl_victim_way;
    logic                  repl_update_en;
    logic [WAY_BITS-1:0]   repl_update_way;

    logic                  meta_rd_en;
    logic [INDEX_BITS-1:0] meta_rd_index;
    logic [WAY_BITS-1:0]   meta_rd_way;
    logic                  victim_valid;
    logic                  victim_dirty;
    logic [TAG_BITS-1:0]   victim_tag;
    logic                  meta_wr_en;
    logic [INDEX_BITS-1:0] meta_wr_index;
    logic [WAY_BITS-1:0]   meta_wr_way;
    logic [TAG_BITS-1:0]   meta_wr_tag;
    logic                  meta_wr_valid;
    logic                  meta_wr_dirty;

    logic                  evict_valid;
    logic                  evict_ready;
    logic [ADDR_W-1:0]     evict_addr;
    logic [WAY_BITS-1:0]   evict_way;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [DATA_W-1:0]     mem_rsp_data;

    logic                  data_wr_en;
    logic [INDEX_BITS-1:0] data_wr_index;
    logic [WAY_BITS-1:0]   data_wr_way;
    logic [BEAT_BITS-1:0]  data_wr_beat;
    logic [DATA_W-1:0]     data_wr_data;

    logic [31:0]           perf_miss_cnt;
    logic [31:0]           perf_evict_cnt;

    modport master (
        input  miss_valid, miss_index, miss_tag,
        output miss_ready, miss_done,
        output repl_index, repl_update_en, repl_update_way,
        input  repl_victim_way,
        output meta_rd_en, meta_rd_index, meta_rd_way,
        input  victim_valid, victim_dirty, victim_tag,
        output meta_wr_en, meta_wr_index, meta_wr_way, meta_wr_tag, meta_wr_valid, meta_wr_dirty,
        output evict_valid, evict_addr, evict_way,
        input  evict_ready,
        output mem_req_valid, mem_req_addr, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output data_wr_en, data_wr_index, data_wr_way, data_wr_beat, data_wr_data,
        output perf_miss_cnt, perf_evict_cnt
    );

    modport slave (
        output miss_valid, miss_index, miss_tag,
        input  miss_ready, miss_done,
        input  repl_index, repl_update_en, repl_update_way,
        output repl_victim_way,
        input  meta_rd_en, meta_rd_index, meta_rd_way,
        output victim_valid, victim_dirty, victim_tag,
        input  meta_wr_en, meta_wr_index, meta_wr_way, meta_wr_tag, meta_wr_valid, meta_wr_dirty,
        input  evict_valid, evict_addr, evict_way,
        output evict_ready,
        input  mem_req_valid, mem_req_addr, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  data_wr_en, data_wr_index, data_wr_way, data_wr_beat, data_wr_data,
        input  perf_miss_cnt, perf_evict_cnt
    );
endinterface

// File: rtl/l1_miss_ctrl.sv
// l1_miss_ctrl: one-at-a-time L1 miss sequencer (victim read, dirty evict, beat refill, tag commit); clean miss
// ready again 8 cycles after accept, stalls on evict_ready/mem_req_ready/beat gaps. Macro L1_MISS_PERF_EN adds counters.
module l1_miss_ctrl #(
    parameter int NUM_SETS    = 64,
    parameter int NUM_WAYS    = 4,
    parameter int INDEX_BITS  = $clog2(NUM_SETS),
    parameter int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int DATA_W      = 32,
    parameter int LINE_BEATS  = 4,
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = $clog2(LINE_BEATS * DATA_W / 8),
    parameter int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
    input logic            clk,
    input logic            rst,
    l1_miss_ctrl_if.master bus
);
    localparam int                   BEAT_BITS = $clog2(LINE_BEATS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_META_RD,
        S_EVICT,
        S_REFILL_REQ,
        S_REFILL_DATA,
        S_COMMIT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [INDEX_BITS-1:0] r_index;
    logic [TAG_BITS-1:0]   r_tag;
    logic [TAG_BITS-1:0]   r_victim_tag;
    logic [WAY_BITS-1:0]   r_way;
    logic [BEAT_BITS-1:0]  r_beat;
    logic                  w_accept;
    logic                  w_beat;

    assign w_accept = (r_state == S_IDLE) && bus.miss_valid;
    assign w_beat   = (r_state == S_REFILL_DATA) && bus.mem_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Victim tag is captured in META_RD because the array only presents it for that one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index      <= '0;
            r_tag        <= '0;
            r_victim_tag <= '0;
            r_way        <= '0;
            r_beat       <= '0;
        end else begin
            if (w_accept) begin
                r_index <= bus.miss_index;
                r_tag   <= bus.miss_tag;
                r_way   <= bus.repl_victim_way;
            end
            if (r_state == S_META_RD) begin
                r_victim_tag <= bus.victim_tag;
            end
            if (r_state == S_REFILL_REQ) begin
                r_beat <= '0;
            end else if (w_beat) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:        if (bus.miss_valid) w_next_state = S_META_RD;
            S_META_RD:     w_next_state = (bus.victim_valid && bus.victim_dirty) ? S_EVICT : S_REFILL_REQ;
            S_EVICT:       if (bus.evict_ready) w_next_state = S_REFILL_REQ;
            S_REFILL_REQ:  if (bus.mem_req_ready) w_next_state = S_REFILL_DATA;
            S_REFILL_DATA: if (bus.mem_rsp_valid && (r_beat == LAST_BEAT)) w_next_state = S_COMMIT;
            S_COMMIT:      w_next_state = S_IDLE;
            default:       w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.miss_ready      = 1'b0;
        bus.miss_done       = 1'b0;
        bus.repl_index      = r_index;
        bus.repl_update_en  = 1'b0;
        bus.repl_update_way = r_way;
        bus.meta_rd_en      = 1'b0;
        bus.meta_rd_index   = bus.miss_index;
        bus.meta_rd_way     = bus.repl_victim_way;
        bus.meta_wr_en      = 1'b0;
        bus.meta_wr_index   = r_index;
        bus.meta_wr_way     = r_way;
        bus.meta_wr_tag     = r_tag;
        bus.meta_wr_valid   = 1'b1;
        bus.meta_wr_dirty   = 1'b0;
        bus.evict_valid     = 1'b0;
        bus.evict_addr      = {r_victim_tag, r_index, {OFFSET_BITS{1'b0}}};
        bus.evict_way       = r_way;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_addr    = {r_tag, r_index, {OFFSET_BITS{1'b0}}};
        bus.mem_rsp_ready   = 1'b0;
        bus.data_wr_en      = 1'b0;
        bus.data_wr_index   = r_index;
        bus.data_wr_way     = r_way;
        bus.data_wr_beat    = r_beat;
        bus.data_wr_data    = bus.mem_rsp_data;
        case (r_state)
            S_IDLE: begin
                bus.miss_ready = 1'b1;
                bus.repl_index = bus.miss_index;
                bus.meta_rd_en = bus.miss_valid;
            end
            S_EVICT:       bus.evict_valid = 1'b1;
            S_REFILL_REQ:  bus.mem_req_valid = 1'b1;
            S_REFILL_DATA: begin
                bus.mem_rsp_ready = 1'b1;
                bus.data_wr_en    = bus.mem_rsp_valid;
            end
            S_COMMIT: begin
                bus.meta_wr_en     = 1'b1;
                bus.repl_update_en = 1'b1;
                bus.miss_done      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef L1_MISS_PERF_EN
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_evict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_miss  <= '0;
            r_perf_evict <= '0;
        end else begin
            if ((r_state == S_COMMIT) && (r_perf_miss != 32'hFFFF_FFFF)) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
            if ((r_state == S_EVICT) && bus.evict_ready && (r_perf_evict != 32'hFFFF_FFFF)) begin
                r_perf_evict <= r_perf_evict + 32'd1;
            end
        end
    end

    assign bus.perf_miss_cnt  = r_perf_miss;
    assign bus.perf_evict_cnt = r_perf_evict;
`else
    assign bus.perf_miss_cnt  = 32'd0;
    assign bus.perf_evict_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_l1_miss_ctrl.sv
// tb_l1_miss_ctrl: directed plus randomized misses against a latency/event model derived from the miss-handling rules.
module tb_l1_miss_ctrl;
    localparam int INDEX_BITS  = 6;
    localparam int WAY_BITS    = 2;
    localparam int DATA_W      = 32;
    localparam int LINE_BEATS  = 4;
    localparam int OFFSET_BITS = 4;
    localparam int TAG_BITS    = 22;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_miss_ctrl_if bus ();
    l1_miss_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int vec_cnt = 0;
    int err_cnt = 0;
    int model_misses = 0;
    int model_evicts = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] t, input logic [INDEX_BITS-1:0] i);
        return (32'(t) << (INDEX_BITS + OFFSET_BITS)) + (32'(i) << OFFSET_BITS);
    endfunction

    task automatic idle_inputs();
        bus.miss_valid      = 1'b0;
        bus.miss_index      = '0;
        bus.miss_tag        = '0;
        bus.repl_victim_way = '0;
        bus.victim_valid    = 1'b0;
        bus.victim_dirty    = 1'b0;
        bus.victim_tag      = '0;
        bus.evict_ready     = 1'b0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_rsp_valid   = 1'b0;
        bus.mem_rsp_data    = '0;
    endtask

    task automatic chk_perf(input string tag);
`ifdef L1_MISS_PERF_EN
        chk({tag, "_perf_miss"}, bus.perf_miss_cnt, 64'(model_misses));
        chk({tag, "_perf_evict"}, bus.perf_evict_cnt, 64'(model_evicts));
`else
        chk({tag, "_perf_miss"}, bus.perf_miss_cnt, 64'd0);
        chk({tag, "_perf_evict"}, bus.perf_evict_cnt, 64'd0);
`endif
    endtask

    // Environment for one miss; es/rs = ready stall cycles, one gap of gap_len cycles after beat gap_after.
    task automatic do_miss(input logic [INDEX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                           input logic [WAY_BITS-1:0] way, input logic vv, input logic vd,
                           input logic [TAG_BITS-1:0] vtag, input int es, input int rs,
                           input int gap_after, input int gap_len);
        logic [DATA_W-1:0] beats [LINE_BEATS];
        int                wr_beat_q [$];
        logic [DATA_W-1:0] wr_data_q [$];
        bit exp_ev, ev_done, req_done, send;
        int exp_lat, ev_cyc, req_cyc, sent, gap_left, done_cyc, meta_cnt, upd_cnt;
        exp_ev   = vv && vd;
        exp_lat  = 7 + (exp_ev ? es + 1 : 0) + rs + ((gap_after >= 0) ? gap_len : 0);
        ev_done  = 0; req_done = 0;
        ev_cyc   = 0; req_cyc = 0; sent = 0; gap_left = gap_len;
        done_cyc = -1; meta_cnt = 0; upd_cnt = 0;
        for (int i = 0; i < LINE_BEATS; i++) beats[i] = $urandom;

        @(negedge clk);
        bus.miss_valid      = 1'b1;
        bus.miss_index      = idx;
        bus.miss_tag        = tag;
        bus.repl_victim_way = way;
        #1;
        chk("accept_ready", bus.miss_ready, 1);
        chk("repl_index_idle", bus.repl_index, idx);
        chk("meta_rd_en", bus.meta_rd_en, 1);
        chk("meta_rd_index", bus.meta_rd_index, idx);
        chk("meta_rd_way", bus.meta_rd_way, way);

        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.miss_valid      = 1'($urandom_range(0, 1));
            bus.miss_index      = INDEX_BITS'($urandom);
            bus.miss_tag        = TAG_BITS'($urandom);
            bus.repl_victim_way = WAY_BITS'($urandom);
            bus.victim_valid    = (cyc == 1) ? vv : 1'($urandom_range(0, 1));
            bus.victim_dirty    = (cyc == 1) ? vd : 1'($urandom_range(0, 1));
            bus.victim_tag      = (cyc == 1) ? vtag : TAG_BITS'($urandom);
            bus.evict_ready     = (ev_cyc >= es);
            bus.mem_req_ready   = (req_cyc >= rs);
            send = 0;
            if (req_done && sent < LINE_BEATS) begin
                if (gap_after >= 0 && sent == gap_after + 1 && gap_left > 0) gap_left--;
                else send = 1;
            end
            bus.mem_rsp_valid = req_done ? send : 1'($urandom_range(0, 1));
            bus.mem_rsp_data  = send ? beats[sent] : DATA_W'($urandom);
            #1;
            chk("busy_ready", bus.miss_ready, 0);
            chk("repl_index_busy", bus.repl_index, idx);
            if (bus.evict_valid) begin
                ev_cyc++;
                chk("evict_addr", bus.evict_addr, line_addr(vtag, idx));
                chk("evict_way", bus.evict_way, way);
                if (bus.evict_ready) ev_done = 1;
            end
            if (bus.mem_req_valid) begin
                chk("req_after_evict", ev_done, exp_ev);
                chk("mem_req_addr", bus.mem_req_addr, line_addr(tag, idx));
                req_cyc++;
                if (bus.mem_req_ready) req_done = 1;
            end
            if (bus.data_wr_en) begin
                wr_beat_q.push_back(int'(bus.data_wr_beat));
                wr_data_q.push_back(bus.data_wr_data);
                chk("data_wr_index", bus.data_wr_index, idx);
                chk("data_wr_way", bus.data_wr_way, way);
            end
            if (send && bus.mem_rsp_ready) sent++;
            if (bus.meta_wr_en) begin
                meta_cnt++;
                chk("meta_wr_tag", bus.meta_wr_tag, tag);
                chk("meta_wr_index", bus.meta_wr_index, idx);
                chk("meta_wr_way", bus.meta_wr_way, way);
                chk("meta_wr_valid", bus.meta_wr_valid, 1);
                chk("meta_wr_dirty", bus.meta_wr_dirty, 0);
            end
            if (bus.repl_update_en) begin
                upd_cnt++;
                chk("repl_update_way", bus.repl_update_way, way);
            end
            if (bus.miss_done) done_cyc = cyc;
        end
        idle_inputs();

        chk("done_latency", 64'(done_cyc), 64'(exp_lat));
        chk("evict_cycles", 64'(ev_cyc), 64'(exp_ev ? es + 1 : 0));
        chk("req_cycles", 64'(req_cyc), 64'(rs + 1));
        chk("meta_wr_count", 64'(meta_cnt), 64'd1);
        chk("repl_update_count", 64'(upd_cnt), 64'd1);
        chk("data_wr_count", 64'(wr_beat_q.size()), 64'(LINE_BEATS));
        for (int i = 0; i < LINE_BEATS && i < wr_beat_q.size(); i++) begin
            chk("data_wr_beat", 64'(wr_beat_q[i]), 64'(i));
            chk("data_wr_data", wr_data_q[i], beats[i]);
        end
        model_misses++;
        if (exp_ev) model_evicts++;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_miss_ready", bus.miss_ready, 1);
        chk("rst_evict_valid", bus.evict_valid, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_rsp_ready", bus.mem_rsp_ready, 0);
        chk("rst_data_wr_en", bus.data_wr_en, 0);
        chk("rst_meta_wr_en", bus.meta_wr_en, 0);
        chk("rst_repl_update_en", bus.repl_update_en, 0);
        chk("rst_miss_done", bus.miss_done, 0);
        chk("rst_meta_rd_en", bus.meta_rd_en, 0);
        chk_perf("rst");

        do_miss(6'd5, 22'h1234, 2'd2, 1'b0, 1'b0, 22'h0, 0, 0, -1, 0);
        do_miss(6'd7, 22'h3333, 2'd1, 1'b1, 1'b1, 22'h0AB, 3, 0, -1, 0);
        do_miss(6'd12, 22'h2222, 2'd3, 1'b0, 1'b1, 22'h55, 0, 5, 1, 1);
        do_miss(6'd20, 22'h0777, 2'd0, 1'b1, 1'b0, 22'h99, 0, 0, -1, 0);
        chk_perf("directed");

        // Reset while refilling, after beats 0 and 1 have been written.
        @(negedge clk);
        bus.miss_valid = 1'b1; bus.miss_index = 6'd9; bus.miss_tag = 22'h4444; bus.repl_victim_way = 2'd1;
        @(negedge clk);
        bus.miss_valid = 1'b0; bus.victim_valid = 1'b0; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_req_valid", bus.mem_req_valid, 1);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = $urandom;
            #1;
            chk("mid_beat_wr", bus.data_wr_en, 1);
            chk("mid_beat_idx", bus.data_wr_beat, b);
        end
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_misses = 0;
        model_evicts = 0;
        for (int c = 0; c < 6; c++) begin
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = $urandom;
            #1;
            chk("abort_miss_ready", bus.miss_ready, 1);
            chk("abort_data_wr_en", bus.data_wr_en, 0);
            chk("abort_meta_wr_en", bus.meta_wr_en, 0);
            chk("abort_repl_update", bus.repl_update_en, 0);
            chk("abort_miss_done", bus.miss_done, 0);
            @(negedge clk);
        end
        idle_inputs();
        chk_perf("abort");

        do_miss(6'd1, 22'h0101, 2'd0, 1'b1, 1'b0, 22'h11, 0, 0, -1, 0);
        do_miss(6'd2, 22'h0202, 2'd1, 1'b1, 1'b1, 22'h22, 1, 1, 0, 2);
        do_miss(6'd3, 22'h0303, 2'd2, 1'b0, 1'b0, 22'h33, 0, 2, 2, 1);
        chk_perf("three");

        for (int n = 0; n < 20; n++) begin
            do_miss(INDEX_BITS'($urandom), TAG_BITS'($urandom), WAY_BITS'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TAG_BITS'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)) - 1, int'($urandom_range(1, 3)));
        end
        @(negedge clk);
        #1;
        chk("final_ready", bus.miss_ready, 1);
        chk_perf("random");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
